fifo_param: RTL and testbench

FIFO_PARAM -- requirements
Module: fifo_param

---
 rtl/fifo_param_if.sv | 29 ++
 rtl/fifo_param.sv | 79 +++++++
 tb/tb_fifo_param.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/fifo_param_if.sv
// Handshake and status bundle shared by fifo_param and whoever drives or consumes it.
interface fifo_param_if #(
  parameter int DATA_W = 6,
  parameter int DEPTH  = 8
);
  logic [DATA_W-1:0]       data_in;
  logic                    fifo_wr;
  logic                    fifo_rd;
  logic [DATA_W-1:0]       data_out;
  logic                    fifo_empty;
  logic                    fifo_full;
  logic                    almost_full;
  logic                    almost_empty;
  logic [$clog2(DEPTH):0]  fifo_count;
  logic                    err_full;
  logic                    err_empty;

  modport master (
    output data_in, fifo_wr, fifo_rd,
    input  data_out, fifo_empty, fifo_full, almost_full, almost_empty,
           fifo_count, err_full, err_empty
  );

  modport slave (
    input  data_in, fifo_wr, fifo_rd,
    output data_out, fifo_empty, fifo_full, almost_full, almost_empty,
           fifo_count, err_full, err_empty
  );
endinterface

// File: rtl/fifo_param.sv
// Single-clock FIFO with registered read data, occupancy flags and error indications.
// FIFO_ERR_STICKY_EN: when defined, err_full/err_empty latch until reset; otherwise 1-cycle pulses.
module fifo_param #(
  parameter int DATA_W    = 6,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = 6,
  parameter int AE_THRESH = 2
) (
  input  logic           clk,
  input  logic           RESET_L,
  fifo_param_if.slave    bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wptr_q, rptr_q;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] dout_q;
  logic              errf_q, errf_d, erre_q, erre_d;
  logic              empty, full, rd_acc, wr_acc, ev_full, ev_empty;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));

  // A read frees a slot in the same edge, so a full FIFO still takes a write alongside it.
  assign rd_acc   = bus.fifo_rd && !empty;
  assign wr_acc   = bus.fifo_wr && (!full || rd_acc);
  assign ev_full  = bus.fifo_wr && !wr_acc;
  assign ev_empty = bus.fifo_rd && empty;

  always_comb begin
    cnt_d = cnt_q;
    if (wr_acc && !rd_acc)      cnt_d = cnt_q + CW'(1);
    else if (rd_acc && !wr_acc) cnt_d = cnt_q - CW'(1);
  end

`ifdef FIFO_ERR_STICKY_EN
  assign errf_d = errf_q || ev_full;
  assign erre_d = erre_q || ev_empty;
`else
  assign errf_d = ev_full;
  assign erre_d = ev_empty;
`endif

  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      dout_q <= '0;
      errf_q <= 1'b0;
      erre_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      errf_q <= errf_d;
      erre_q <= erre_d;
      if (wr_acc) wptr_q <= wptr_q + AW'(1);
      if (rd_acc) begin
        rptr_q <= rptr_q + AW'(1);
        dout_q <= mem_q[rptr_q];
      end
    end
  end

  // Storage is deliberately left out of reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wptr_q] <= bus.data_in;
  end

  assign bus.data_out     = dout_q;
  assign bus.fifo_count   = cnt_q;
  assign bus.fifo_empty   = empty;
  assign bus.fifo_full    = full;
  assign bus.almost_full  = (cnt_q >= CW'(AF_THRESH));
  assign bus.almost_empty = (cnt_q <= CW'(AE_THRESH));
  assign bus.err_full     = errf_q;
  assign bus.err_empty    = erre_q;
endmodule

// File: tb/tb_fifo_param.sv
// Directed bench for fifo_param: queue-based reference model checked every cycle plus literal expectations.
module tb_fifo_param;
  localparam int DW = 6;
  localparam int DEPTH = 8;
  localparam int AFT = 6;
  localparam int AET = 2;
`ifdef FIFO_ERR_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic clk = 1'b0;
  logic RESET_L = 1'b1;
  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  fifo_param_if #(.DATA_W(DW), .DEPTH(DEPTH)) bus ();

  fifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .AF_THRESH(AFT), .AE_THRESH(AET)) dut (
    .clk     (clk),
    .RESET_L (RESET_L),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: a plain queue of accepted words.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout;
  bit m_ef, m_ee;

  always @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      q.delete();
      m_dout = '0;
      m_ef = 1'b0;
      m_ee = 1'b0;
    end else begin
      bit rd_ok, wr_ok;
      rd_ok = bus.fifo_rd && (q.size() > 0);
      wr_ok = bus.fifo_wr && ((q.size() < DEPTH) || rd_ok);
      if (rd_ok) m_dout = q.pop_front();
      if (wr_ok) q.push_back(bus.data_in);
      m_ef = (STICKY && m_ef) || (bus.fifo_wr && !wr_ok);
      m_ee = (STICKY && m_ee) || (bus.fifo_rd && !rd_ok);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_data_out", int'(bus.data_out), int'(m_dout));
      chk("m_count", int'(bus.fifo_count), q.size());
      chk("m_empty", int'(bus.fifo_empty), int'(q.size() == 0));
      chk("m_full", int'(bus.fifo_full), int'(q.size() == DEPTH));
      chk("m_afull", int'(bus.almost_full), int'(q.size() >= AFT));
      chk("m_aempty", int'(bus.almost_empty), int'(q.size() <= AET));
      chk("m_err_full", int'(bus.err_full), int'(m_ef));
      chk("m_err_empty", int'(bus.err_empty), int'(m_ee));
    end
  end

  // Inputs change at negedge; the following posedge applies them; outputs checked 1 time unit later.
  task automatic step(input logic wr, input logic rd, input logic [DW-1:0] d);
    @(negedge clk);
    bus.fifo_wr = wr;
    bus.fifo_rd = rd;
    bus.data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.fifo_wr = 1'b0;
    bus.fifo_rd = 1'b0;
    #1 RESET_L = 1'b0;
    #2 RESET_L = 1'b1;
  endtask

  initial begin
    bus.fifo_wr = 1'b0;
    bus.fifo_rd = 1'b0;
    bus.data_in = '0;
    #1 RESET_L = 1'b0;
    #2;
    chk("rst_count", int'(bus.fifo_count), 0);
    chk("rst_empty", int'(bus.fifo_empty), 1);
    chk("rst_aempty", int'(bus.almost_empty), 1);
    chk("rst_full", int'(bus.fifo_full), 0);
    chk("rst_afull", int'(bus.almost_full), 0);
    chk("rst_dout", int'(bus.data_out), 0);
    chk("rst_errs", int'({bus.err_full, bus.err_empty}), 0);
    #10 RESET_L = 1'b1;
    chk_en = 1'b1;

    // Single word round trip
    step(1'b1, 1'b0, 6'b010010);
    chk("one_count", int'(bus.fifo_count), 1);
    step(1'b0, 1'b1, '0);
    chk("one_dout", int'(bus.data_out), 'b010010);
    chk("one_empty", int'(bus.fifo_empty), 1);
    chk("one_count0", int'(bus.fifo_count), 0);
    step(1'b0, 1'b0, '0);
    chk("one_hold", int'(bus.data_out), 'b010010);

    // Fill to full, overflow, drain
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b0, DW'(i));
      if (i == 5) chk("fill_af5", int'(bus.almost_full), 0);
      if (i == 6) chk("fill_af6", int'(bus.almost_full), 1);
    end
    chk("fill_count", int'(bus.fifo_count), 8);
    chk("fill_full", int'(bus.fifo_full), 1);
    step(1'b1, 1'b0, 6'h3F);
    chk("ovf_err", int'(bus.err_full), 1);
    chk("ovf_count", int'(bus.fifo_count), 8);
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b1, '0);
      chk("drain_dout", int'(bus.data_out), i);
      if (i == 1) chk("ovf_err_after", int'(bus.err_full), int'(STICKY));
    end
    chk("drain_empty", int'(bus.fifo_empty), 1);

    // Pointer wrap-around
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, DW'(10 + i));
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, '0);
    chk("wrap_pre_dout", int'(bus.data_out), 14);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, DW'(20 + i));
      if (i == 1) chk("wrap_ae2", int'(bus.almost_empty), 1);
      if (i == 2) chk("wrap_ae3", int'(bus.almost_empty), 0);
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, '0);
      chk("wrap_dout", int'(bus.data_out), 20 + i);
    end

    // Simultaneous read/write while full
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, DW'('h30 + i));
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 6'h2A);
      chk("rw_full_count", int'(bus.fifo_count), 8);
      chk("rw_full_err", int'(bus.err_full), 0);
      chk("rw_full_dout", int'(bus.data_out), 'h30 + i);
    end
    for (int i = 3; i < 8; i++) begin
      step(1'b0, 1'b1, '0);
      chk("rw_tail_dout", int'(bus.data_out), 'h30 + i);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, '0);
      chk("rw_2a_dout", int'(bus.data_out), 'h2A);
    end

    // Simultaneous read/write while empty, then underflow
    do_reset();
    step(1'b1, 1'b1, 6'h07);
    chk("rw_empty_count", int'(bus.fifo_count), 1);
    chk("rw_empty_err", int'(bus.err_empty), 1);
    chk("rw_empty_dout", int'(bus.data_out), 0);
    step(1'b0, 1'b1, '0);
    chk("rw_empty_rd", int'(bus.data_out), 7);
    chk("rw_empty_err2", int'(bus.err_empty), int'(STICKY));
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, '0);
      chk("udf_err", int'(bus.err_empty), 1);
      chk("udf_dout", int'(bus.data_out), 7);
    end
    step(1'b0, 1'b0, '0);
    chk("udf_err_after", int'(bus.err_empty), int'(STICKY));

    // Asynchronous reset mid-operation
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, DW'(40 + i));
    step(1'b0, 1'b1, '0);
    chk("mid_pre_dout", int'(bus.data_out), 40);
    #2;
    bus.fifo_wr = 1'b0;
    bus.fifo_rd = 1'b0;
    RESET_L = 1'b0;
    #1;
    chk("mid_count", int'(bus.fifo_count), 0);
    chk("mid_dout", int'(bus.data_out), 0);
    chk("mid_empty", int'(bus.fifo_empty), 1);
    #10 RESET_L = 1'b1;
    step(1'b1, 1'b0, 6'h15);
    step(1'b0, 1'b1, '0);
    chk("mid_after_dout", int'(bus.data_out), 'h15);
    chk("mid_after_empty", int'(bus.fifo_empty), 1);

    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
